// File: rtl/subservient_wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-byte-SRAM bridge: state encoding,
// lane count and the byte-lane extraction helper.
package subservient_wb_sram_pkg;

    localparam int LANES = 4;
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        XFER  = ST_XFER,
        DRAIN = ST_DRAIN,
        ACK   = ST_ACK
    } state_t;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] k);
        return word[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/subservient_wb_sram_bridge.sv
// Wishbone slave that splits each 32-bit word access into four sequential
// byte accesses on a byte-wide SRAM with one-cycle registered read data.
module subservient_wb_sram_bridge
    import subservient_wb_sram_pkg::*;
#(
    parameter int depth = 0,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [aw-3:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic [aw-1:0] o_sram_waddr,
    output logic [7:0]    o_sram_wdata,
    output logic          o_sram_wen,
    output logic [aw-1:0] o_sram_raddr,
    input  logic [7:0]    i_sram_rdata,
    output logic          o_sram_ren
);

    state_t        state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;

    logic [aw-3:0] adr_q, adr_nxt;
    logic [31:0]   dat_q, dat_nxt;
    logic [3:0]    sel_q, sel_nxt;
    logic          we_q, we_nxt;

    logic [aw-1:0] addr_q, addr_nxt;
    logic [7:0]    wdata_q, wdata_nxt;
    logic          wen_q, wen_nxt;
    logic          ren_q, ren_nxt;

    logic [31:0]   rdt_q;
    logic          rd_pend;
    logic [1:0]    rd_lane;

    // SRAM outputs are registered, so they are computed from the state the
    // bridge is about to enter; the accepted request feeds lane 0 directly.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        adr_nxt   = adr_q;
        dat_nxt   = dat_q;
        sel_nxt   = sel_q;
        we_nxt    = we_q;

        case (state)
            IDLE: begin
                if (i_wb_cyc) begin
                    state_nxt = XFER;
                    cnt_nxt   = 2'd0;
                    adr_nxt   = i_wb_adr;
                    dat_nxt   = i_wb_dat;
                    sel_nxt   = i_wb_sel;
                    we_nxt    = i_wb_we;
                end
            end
            XFER: begin
                if (cnt == LAST_LANE) begin
                    state_nxt = we_q ? ACK : DRAIN;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            DRAIN: state_nxt = ACK;
            ACK: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
            default: state_nxt = IDLE;
        endcase

        addr_nxt  = '0;
        wdata_nxt = '0;
        wen_nxt   = 1'b0;
        ren_nxt   = 1'b0;
        if (state_nxt == XFER) begin
            addr_nxt  = {adr_nxt, cnt_nxt};
            wdata_nxt = lane_byte(dat_nxt, cnt_nxt);
            wen_nxt   = we_nxt & sel_nxt[cnt_nxt];
            ren_nxt   = ~we_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            adr_q   <= adr_nxt;
            dat_q   <= dat_nxt;
            sel_q   <= sel_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            wen_q   <= wen_nxt;
            ren_q   <= ren_nxt;
        end
    end

    // The RAM answers a read one cycle after ren, so the lane being read is
    // remembered for one cycle and captured when its byte arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_pend <= 1'b0;
            rd_lane <= 2'd0;
            rdt_q   <= '0;
        end else begin
            rd_pend <= ren_q;
            rd_lane <= cnt;
            if (rd_pend) begin
                rdt_q[{rd_lane, 3'b000} +: 8] <= i_sram_rdata;
            end
        end
    end

    assign o_wb_ack     = (state == ACK);
    assign o_wb_rdt     = rdt_q;
    assign o_sram_waddr = addr_q;
    assign o_sram_raddr = addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_sram_wen   = wen_q;
    assign o_sram_ren   = ren_q;

endmodule

// File: tb/tb_subservient_wb_sram_bridge.sv
// Bench for subservient_wb_sram_bridge paired with a 64-byte generic RAM; a
// transaction-level model predicts every output cycle by cycle.
module tb_subservient_wb_sram_bridge;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int N     = 4096;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [AW-3:0] i_wb_adr = '0;
    logic [31:0]   i_wb_dat = '0;
    logic [3:0]    i_wb_sel = '0;
    logic          i_wb_we  = 1'b0;
    logic          i_wb_cyc = 1'b0;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack;
    logic [AW-1:0] o_sram_waddr;
    logic [7:0]    o_sram_wdata;
    logic          o_sram_wen;
    logic [AW-1:0] o_sram_raddr;
    logic [7:0]    i_sram_rdata;
    logic          o_sram_ren;

    always #5 i_clk = ~i_clk;

    subservient_wb_sram_bridge #(.depth(DEPTH), .aw(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
        .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .o_sram_waddr(o_sram_waddr), .o_sram_wdata(o_sram_wdata), .o_sram_wen(o_sram_wen),
        .o_sram_raddr(o_sram_raddr), .i_sram_rdata(i_sram_rdata), .o_sram_ren(o_sram_ren)
    );

    // Generic RAM: byte write and registered byte read.
    logic [7:0] ram [DEPTH];
    always @(posedge i_clk) begin
        if (o_sram_wen) ram[o_sram_waddr] <= o_sram_wdata;
        if (o_sram_ren) i_sram_rdata <= ram[o_sram_raddr];
    end

    int cyc_n = 0;
    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    // Model state and per-cycle expectations.
    logic [7:0]    ref_mem [DEPTH];
    logic [31:0]   model_rdt = '0;
    int            model_free = 0;
    int            last_accept = 0;
    logic          exp_wen [N], exp_ren [N], exp_ack [N], exp_wdchk [N], exp_rdtchk [N];
    logic [AW-1:0] exp_addr [N];
    logic [7:0]    exp_wdata [N];
    logic [31:0]   exp_rdt [N];

    logic          obs_wen [N], obs_ren [N], obs_ack [N];
    logic [AW-1:0] obs_waddr [N], obs_raddr [N];
    logic [7:0]    obs_wdata [N];
    logic [31:0]   obs_rdt [N];
    int            ack_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, c, act, exp);
        end
    endtask

    task automatic clearExp(input int c);
        if (c < N) begin
            exp_wen[c] = 1'b0; exp_ren[c] = 1'b0; exp_ack[c] = 1'b0;
            exp_addr[c] = '0; exp_wdata[c] = '0; exp_wdchk[c] = 1'b1;
            exp_rdt[c] = '0; exp_rdtchk[c] = 1'b0;
        end
    endtask

    // A request accepted in cycle t0 shows lanes in t0+1..t0+4 and acks in
    // t0+5 (write) or t0+6 (read).
    task automatic plan(input int t0, input logic [AW-3:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w);
        logic [AW-1:0] ba;
        int            ackc;
        for (int k = 0; k < 4; k++) begin
            ba = {a, 2'(k)};
            exp_addr[t0+1+k] = ba;
            if (w) begin
                exp_wen[t0+1+k]   = s[k];
                exp_wdata[t0+1+k] = d[8*k +: 8];
                if (s[k]) ref_mem[ba] = d[8*k +: 8];
            end else begin
                exp_ren[t0+1+k]   = 1'b1;
                exp_wdchk[t0+1+k] = 1'b0;
            end
        end
        if (!w) model_rdt = {ref_mem[{a, 2'd3}], ref_mem[{a, 2'd2}], ref_mem[{a, 2'd1}], ref_mem[{a, 2'd0}]};
        ackc = t0 + (w ? 5 : 6);
        exp_ack[ackc] = 1'b1;
        for (int j = 0; j < 2; j++) begin
            exp_rdtchk[ackc+j] = 1'b1;
            exp_rdt[ackc+j]    = model_rdt;
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic [AW-3:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic w);
        @(posedge i_clk); #1;
        i_wb_cyc = cyc; i_wb_adr = a; i_wb_dat = d; i_wb_sel = s; i_wb_we = w;
        if (cyc && cyc_n >= model_free && cyc_n + 8 < N) begin
            plan(cyc_n, a, d, s, w);
            last_accept = cyc_n;
            model_free  = cyc_n + (w ? 6 : 7);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic doRequest(input logic [AW-3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic w, output int t0);
        applyStimulus(1'b1, a, d, s, w);
        t0 = last_accept;
        idle(w ? 5 : 6);
    endtask

    // Compare process: every cycle, outputs against the model.
    always @(negedge i_clk) begin
        if (cyc_n < N) begin
            obs_wen[cyc_n] = o_sram_wen;   obs_ren[cyc_n] = o_sram_ren;
            obs_ack[cyc_n] = o_wb_ack;     obs_wdata[cyc_n] = o_sram_wdata;
            obs_waddr[cyc_n] = o_sram_waddr; obs_raddr[cyc_n] = o_sram_raddr;
            obs_rdt[cyc_n] = o_wb_rdt;
            if (o_wb_ack === 1'b1) ack_q.push_back(cyc_n);
            checkOutput("wen", cyc_n, 32'(o_sram_wen), 32'(exp_wen[cyc_n]));
            checkOutput("ren", cyc_n, 32'(o_sram_ren), 32'(exp_ren[cyc_n]));
            checkOutput("ack", cyc_n, 32'(o_wb_ack), 32'(exp_ack[cyc_n]));
            checkOutput("waddr", cyc_n, 32'(o_sram_waddr), 32'(exp_addr[cyc_n]));
            checkOutput("raddr", cyc_n, 32'(o_sram_raddr), 32'(exp_addr[cyc_n]));
            if (exp_wdchk[cyc_n]) checkOutput("wdata", cyc_n, 32'(o_sram_wdata), 32'(exp_wdata[cyc_n]));
            if (exp_rdtchk[cyc_n]) checkOutput("rdt", cyc_n, o_wb_rdt, exp_rdt[cyc_n]);
        end
    end

    initial begin
        int            t0, t1, nack;
        logic [7:0]    bytes [4];
        logic [7:0]    saved [4];

        for (int i = 0; i < N; i++) clearExp(i);
        for (int i = 0; i < 4; i++) exp_rdtchk[i] = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        model_free = cyc_n + 1;

        for (int w = 0; w < 16; w++) doRequest(AW-2'(w), $urandom, 4'hF, 1'b1, t0);

        $display("[TB] full write");
        doRequest(4'd3, 32'hDEADBEEF, 4'hF, 1'b1, t0);
        idle(2);
        bytes[0] = 8'hEF; bytes[1] = 8'hBE; bytes[2] = 8'hAD; bytes[3] = 8'hDE;
        for (int k = 0; k < 4; k++) begin
            checkOutput("fw_wen", t0+1+k, 32'(obs_wen[t0+1+k]), 32'd1);
            checkOutput("fw_addr", t0+1+k, 32'(obs_waddr[t0+1+k]), 32'(12 + k));
            checkOutput("fw_data", t0+1+k, 32'(obs_wdata[t0+1+k]), 32'(bytes[k]));
        end
        checkOutput("fw_ack5", t0+5, 32'(obs_ack[t0+5]), 32'd1);
        checkOutput("fw_ack4", t0+4, 32'(obs_ack[t0+4]), 32'd0);
        checkOutput("fw_ack6", t0+6, 32'(obs_ack[t0+6]), 32'd0);
        checkOutput("model_mem12", 0, 32'(ref_mem[12]), 32'hEF);

        $display("[TB] partial write then read");
        doRequest(4'd3, 32'h11223344, 4'h5, 1'b1, t0);
        idle(2);
        checkOutput("pw_wen1", t0+1, 32'(obs_wen[t0+1]), 32'd1);
        checkOutput("pw_wen2", t0+2, 32'(obs_wen[t0+2]), 32'd0);
        checkOutput("pw_wen3", t0+3, 32'(obs_wen[t0+3]), 32'd1);
        checkOutput("pw_wen4", t0+4, 32'(obs_wen[t0+4]), 32'd0);
        checkOutput("pw_d1", t0+1, 32'(obs_wdata[t0+1]), 32'h44);
        checkOutput("pw_d3", t0+3, 32'(obs_wdata[t0+3]), 32'h22);
        doRequest(4'd3, '0, '0, 1'b0, t0);
        idle(2);
        checkOutput("rd_ack6", t0+6, 32'(obs_ack[t0+6]), 32'd1);
        checkOutput("rd_ack5", t0+5, 32'(obs_ack[t0+5]), 32'd0);
        checkOutput("rd_word", t0+6, obs_rdt[t0+6], 32'hDE22BE44);

        $display("[TB] read latency");
        doRequest(4'd15, 32'h04030201, 4'hF, 1'b1, t0);
        doRequest(4'd15, '0, '0, 1'b0, t0);
        idle(2);
        for (int k = 0; k < 4; k++) begin
            checkOutput("rl_ren", t0+1+k, 32'(obs_ren[t0+1+k]), 32'd1);
            checkOutput("rl_addr", t0+1+k, 32'(obs_raddr[t0+1+k]), 32'(60 + k));
        end
        for (int c = t0; c <= t0+6; c++) checkOutput("rl_nowen", c, 32'(obs_wen[c]), 32'd0);
        checkOutput("rl_ack", t0+6, 32'(obs_ack[t0+6]), 32'd1);
        checkOutput("rl_word", t0+6, obs_rdt[t0+6], 32'h04030201);

        $display("[TB] back-to-back");
        nack = ack_q.size();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 4'd7, 32'hCAFE0000 + 32'(i), 4'hF, 1'b1);
            if (i == 0) t0 = last_accept;
        end
        idle(3);
        checkOutput("b2b_acks", t0, 32'(ack_q.size() - nack), 32'd2);
        checkOutput("b2b_ack1", t0, 32'(ack_q[nack]), 32'(t0 + 5));
        checkOutput("b2b_ack2", t0, 32'(ack_q[nack+1]), 32'(t0 + 11));
        checkOutput("b2b_gap", t0+6, 32'(obs_wen[t0+6]), 32'd0);
        checkOutput("b2b_lane0", t0+7, 32'(obs_wen[t0+7]), 32'd1);
        checkOutput("b2b_addr0", t0+7, 32'(obs_waddr[t0+7]), 32'd28);

        $display("[TB] reset mid-write");
        doRequest(4'd5, 32'hAABBCCDD, 4'hF, 1'b1, t0);
        for (int k = 0; k < 4; k++) saved[k] = ref_mem[20 + k];
        applyStimulus(1'b1, 4'd5, 32'h11223344, 4'hF, 1'b1);
        t0 = last_accept;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        nack = ack_q.size();
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        for (int c = cyc_n; c < cyc_n + 13; c++) clearExp(c);
        for (int c = cyc_n; c < cyc_n + 4; c++) exp_rdtchk[c] = 1'b1;
        for (int k = 1; k < 4; k++) ref_mem[20 + k] = saved[k];
        model_rdt = '0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        model_free = cyc_n + 1;
        idle(6);
        checkOutput("rst_wen", t0+2, 32'(obs_wen[t0+2]), 32'd0);
        checkOutput("rst_addr", t0+2, 32'(obs_waddr[t0+2]), 32'd0);
        checkOutput("rst_rdt", t0+2, obs_rdt[t0+2], 32'd0);
        checkOutput("rst_noack", t0, 32'(ack_q.size() - nack), 32'd0);
        doRequest(4'd5, '0, '0, 1'b0, t1);
        idle(2);
        checkOutput("rst_ack", t1+6, 32'(obs_ack[t1+6]), 32'd1);
        checkOutput("rst_word", t1+6, obs_rdt[t1+6], 32'hAABBCC44);

        $display("[TB] cyc drop during read");
        nack = ack_q.size();
        applyStimulus(1'b1, 4'd15, '0, '0, 1'b0);
        t0 = last_accept;
        applyStimulus(1'b1, 4'd15, '0, '0, 1'b0);
        idle(9);
        checkOutput("drop_ack", t0+6, 32'(obs_ack[t0+6]), 32'd1);
        checkOutput("drop_acks", t0, 32'(ack_q.size() - nack), 32'd1);
        checkOutput("drop_word", t0+6, obs_rdt[t0+6], 32'h04030201);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom % 3) != 0, 4'($urandom), $urandom, 4'($urandom), 1'($urandom));
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/subservient_wb_sram_bridge.md
# subservient_wb_sram_bridge

Wishbone-slave to byte-wide SRAM initiator. Converts 32-bit Wishbone word accesses into four sequential byte accesses on the single-port-style SRAM interface of the team's generic RAM (separate write/read address, `wen`, `ren`, one-cycle registered read data). It sits between the CPU data bus and the shared SRAM and drives the SRAM side of that interface.

## Interface
Parameters:
- `depth`, 0: SRAM size in bytes; must be a multiple of 4 and at least 4.
- `aw`, `$clog2(depth)`: SRAM byte-address width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_wb_adr`  in  aw-2  word address; drives bits [aw-1:2] of the byte address.
- `i_wb_dat`  in  32  write data, little-endian (byte k = bits [8k+7:8k]).
- `i_wb_sel`  in  4  byte-lane write enables.
- `i_wb_we`  in  1  1 = write, 0 = read.
- `i_wb_cyc`  in  1  request strobe (cyc/stb combined).
- `o_wb_rdt`  out  32  read data, valid while `o_wb_ack` is high.
- `o_wb_ack`  out  1  one-cycle completion pulse.
- `o_sram_waddr`  out  aw  SRAM write byte address.
- `o_sram_wdata`  out  8  SRAM write byte.
- `o_sram_wen`  out  1  SRAM write enable.
- `o_sram_raddr`  out  aw  SRAM read byte address.
- `i_sram_rdata`  in  8  SRAM read byte; the RAM returns it one cycle after `ren`.
- `o_sram_ren`  out  1  SRAM read enable.

## Operation
- States: IDLE, XFER, DRAIN, ACK. A 2-bit lane counter `cnt` counts 0..3.
- IDLE: when `i_wb_cyc` is sampled high, latch `adr`, `dat`, `sel`, `we`, set `cnt`=0, and go to XFER.
- XFER: issue one byte per cycle for lanes 0,1,2,3 in order. Both `o_sram_waddr` and `o_sram_raddr` = {adr, cnt}.
  - Write: `o_sram_wen` = `sel[cnt]`. `o_sram_wdata` = lane `cnt` of the latched data. Unselected lanes still use a cycle, so latency is fixed.
  - Read: `o_sram_ren` = 1 for all four lanes; `sel` is ignored.
  - After lane 3, a write goes to ACK and a read goes to DRAIN.
- DRAIN (read only): capture the lane-3 byte, then go to ACK.
- Read capture: the byte issued in cycle c is stored into lane c-1's position of the `rdt` register at the end of cycle c+1.
- ACK: `o_wb_ack`=1 for exactly one cycle, then IDLE. `i_wb_cyc` is not sampled during ACK.
- `i_wb_cyc` dropping during XFER/DRAIN has no effect; the transfer completes and acks.
- All SRAM outputs are registered. In every cycle outside XFER: `wen`=`ren`=0, addresses=0, `wdata`=0.
- `o_wb_rdt` holds its last captured value between accesses. Write accesses do not modify it.
- Byte address never exceeds `depth`-1; no wrap logic is required beyond the width of `aw`.

## Timing
- Reset (asynchronous assert, synchronous-release safe): state=IDLE, `cnt`=0, `o_wb_ack`=0, `o_wb_rdt`=0, `o_sram_wen`=0, `o_sram_ren`=0, `o_sram_waddr`=`o_sram_raddr`=0, `o_sram_wdata`=0.
- Reset mid-transfer aborts the transfer immediately: no further `wen`, no ack. A partially written word is left as-is.
- Cycle 0 = the cycle in which `i_wb_cyc` is high in IDLE.
  - Lanes 0..3 appear on the SRAM port in cycles 1..4.
  - Write: `o_wb_ack` is high in cycle 5.
  - Read: DRAIN is cycle 5; `o_wb_ack` is high in cycle 6 with the full word on `o_wb_rdt`.
- Back-to-back: a new request is accepted no earlier than the cycle after ack. Minimum period is 6 cycles for a write and 7 for a read.

## Structure
- Shared package `subservient_wb_sram_pkg`:
  - state encoding localparams (IDLE/XFER/DRAIN/ACK, 2 bits);
  - `LANES`=4;
  - the lane-select helper function for extracting byte k of a 32-bit word.
- Single module; no sub-module is needed. The lane counter and state register stay in this block.
- Target size: 150–250 lines of RTL.

## Test plan
Bench pairs the bridge with the team's generic RAM model (`depth`=64).
- Full write: adr=3, dat=0xDEADBEEF, sel=0xF, we=1 → `wen` high in cycles 1–4 at byte addresses 12,13,14,15 with data EF,BE,AD,DE; ack in cycle 5 only.
- Partial write, then read: write adr=3, dat=0x11223344, sel=0x5 → `wen` only in cycles 1 and 3 (bytes 44, 22). A following read of adr=3 returns 0xDE22BE44 with ack in cycle 6.
- Read latency: read adr=15 after the RAM is preloaded with bytes 60..63 = 01,02,03,04 → `ren` high in cycles 1–4 at addresses 60–63. `o_wb_rdt`=0x04030201 with ack in cycle 6; `wen` never high.
- Back-to-back: hold `i_wb_cyc` high across two writes → second lane 0 appears in cycle 7. `i_wb_cyc` is ignored during the ack cycle; exactly two ack pulses.
- Reset mid-write: assert `i_rst` in cycle 2 of a sel=0xF write → all outputs 0 immediately; only byte 0 is modified in the RAM; no ack. After release, the next request behaves normally.
- Cyc drop: deassert `i_wb_cyc` in cycle 2 of a read → the transfer still completes with ack in cycle 6; the bridge then stays IDLE.
